// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: round-robin sharing of one RAM read port among N_REQ level-handshake requesters,
// with a sticky watchdog that answers a stalled read with a zero word.
module ram_read_arbiter #(
  parameter int N_REQ        = 4,
  parameter int RAM_WID      = 32,
  parameter int RAM_WORD_WID = 16,
  parameter int TIMEOUT_WID  = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                     clk,
  input  logic                     rst_L,
  input  logic [N_REQ-1:0]         req_read,
  input  logic [N_REQ*RAM_WID-1:0] req_addr,
  output logic [RAM_WORD_WID-1:0]  req_word,
  output logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         grant,
  output logic [RAM_WID-1:0]       ram_dma_addr,
  output logic                     ram_read,
  input  logic [RAM_WORD_WID-1:0]  ram_word,
  input  logic                     ram_valid,
  output logic                     timeout_err,
  input  logic                     timeout_clr
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t state;
  logic [IW-1:0] last, idx, pick;
  logic [TIMEOUT_WID-1:0] cnt;
  // Scan downward so the lowest offset after last wins.
  always_comb begin
    pick = '0;
    for (int o = N_REQ; o >= 1; o--)
      if (req_read[(int'(last) + o) % N_REQ]) pick = IW'((int'(last) + o) % N_REQ);
  end
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state        <= IDLE;
      last         <= IW'(N_REQ - 1);
      idx          <= '0;
      cnt          <= '0;
      req_word     <= '0;
      req_valid    <= '0;
      grant        <= '0;
      ram_dma_addr <= '0;
      ram_read     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (timeout_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: if (|req_read) begin
          idx          <= pick;
          grant        <= ONE << pick;
          ram_dma_addr <= req_addr[pick*RAM_WID +: RAM_WID];
          ram_read     <= 1'b1;
          cnt          <= '0;
          state        <= BUSY;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (ram_valid) begin
            ram_read <= 1'b0;
            if (req_read[idx]) begin
              req_word  <= ram_word;
              req_valid <= ONE << idx;
              state     <= RELEASE;
            end else begin
              last  <= idx;
              grant <= '0;
              state <= IDLE;
            end
          end else if (cnt == TIMEOUT_WID'(TIMEOUT)) begin
            ram_read    <= 1'b0;
            timeout_err <= 1'b1;
            req_word    <= '0;
            req_valid   <= ONE << idx;
            state       <= RELEASE;
          end
        end
        RELEASE: if (!req_read[idx]) begin
          req_valid <= '0;
          grant     <= '0;
          last      <= idx;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_read_arbiter.sv
// tb_ram_read_arbiter: directed checks of ram_read_arbiter handshake, round-robin, abort, watchdog and reset.
module tb_ram_read_arbiter;
  logic         clk = 1'b0, rst_L = 1'b0;
  logic [3:0]   req_read = '0;
  logic [127:0] req_addr = '0;
  logic [15:0]  req_word, ram_word = '0;
  logic [3:0]   req_valid, grant;
  logic [31:0]  ram_dma_addr;
  logic         ram_read, ram_valid = 1'b0, timeout_err, timeout_clr = 1'b0;
  int vectors = 0, miscompares = 0;

  ram_read_arbiter dut (
    .clk(clk), .rst_L(rst_L), .req_read(req_read), .req_addr(req_addr),
    .req_word(req_word), .req_valid(req_valid), .grant(grant),
    .ram_dma_addr(ram_dma_addr), .ram_read(ram_read), .ram_word(ram_word),
    .ram_valid(ram_valid), .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_L = 1'b0;
    tick;
    tick;
    rst_L = 1'b1;
  endtask

  task automatic wait_read;
    int n = 0;
    while (!ram_read && n < 20) begin
      tick;
      n++;
    end
    chk("wait_ram_read", 32'(ram_read), 32'd1);
  endtask

  // One full transaction for requester i: issue, RAM answers after lat cycles, requester drops read.
  task automatic rw(input int i, input logic [31:0] addr, input int lat, input logic [15:0] w, input bit reraise);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    wait_read;
    chk("rw_grant", 32'(grant), 32'(oh));
    chk("rw_addr", ram_dma_addr, addr);
    repeat (lat - 1) tick;
    ram_valid = 1'b1;
    ram_word = w;
    tick;
    ram_valid = 1'b0;
    chk("rw_valid", 32'(req_valid), 32'(oh));
    chk("rw_word", 32'(req_word), 32'(w));
    chk("rw_read_low", 32'(ram_read), 32'd0);
    req_read[i] = 1'b0;
    tick;
    chk("rw_valid_clr", 32'(req_valid), 32'd0);
    chk("rw_grant_clr", 32'(grant), 32'd0);
    if (reraise) req_read[i] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick;
    chk("rst_word", 32'(req_word), 32'd0);
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_addr", ram_dma_addr, 32'd0);
    chk("rst_read", 32'(ram_read), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    tick;
    rst_L = 1'b1;
    // Single requester, RAM latency 2.
    req_addr[31:0] = 32'h100;
    req_read = 4'b0001;
    rw(0, 32'h100, 2, 16'hBEEF, 1'b0);
    // All requesters held high: grants 0,1,2,3,0.
    for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h1000 + 32'(i * 16);
    do_reset;
    req_read = 4'b1111;
    rw(0, 32'h1000, 1, 16'hA000, 1'b1);
    rw(1, 32'h1010, 1, 16'hA001, 1'b1);
    rw(2, 32'h1020, 1, 16'hA002, 1'b1);
    rw(3, 32'h1030, 1, 16'hA003, 1'b1);
    rw(0, 32'h1000, 1, 16'hA004, 1'b0);
    req_read = 4'b0000;
    tick;
    // Requester 2 aborts during BUSY, then 3 is served; address change while granted is ignored.
    do_reset;
    req_read = 4'b1100;
    wait_read;
    chk("abort_grant", 32'(grant), 32'h4);
    req_read[2] = 1'b0;
    tick;
    chk("abort_busy_read", 32'(ram_read), 32'd1);
    ram_valid = 1'b1;
    ram_word = 16'hDEAD;
    tick;
    ram_valid = 1'b0;
    chk("abort_read_low", 32'(ram_read), 32'd0);
    chk("abort_no_valid", 32'(req_valid), 32'd0);
    chk("abort_grant_clr", 32'(grant), 32'd0);
    tick;
    chk("next_grant", 32'(grant), 32'h8);
    chk("next_addr", ram_dma_addr, 32'h1030);
    req_addr[127:96] = 32'hFFFF_0000;
    ram_valid = 1'b1;
    ram_word = 16'h3333;
    tick;
    ram_valid = 1'b0;
    chk("next_valid", 32'(req_valid), 32'h8);
    chk("next_word", 32'(req_word), 32'h3333);
    chk("addr_held", ram_dma_addr, 32'h1030);
    req_read = 4'b0000;
    req_addr[127:96] = 32'h1030;
    tick;
    chk("next_valid_clr", 32'(req_valid), 32'd0);
    // Watchdog: RAM never answers.
    req_read = 4'b0010;
    wait_read;
    repeat (255) tick;
    chk("to_read_still", 32'(ram_read), 32'd1);
    chk("to_err_before", 32'(timeout_err), 32'd0);
    tick;
    chk("to_read_low", 32'(ram_read), 32'd0);
    chk("to_err_set", 32'(timeout_err), 32'd1);
    chk("to_valid", 32'(req_valid), 32'h2);
    chk("to_word", 32'(req_word), 32'd0);
    req_read = 4'b0000;
    tick;
    chk("to_valid_clr", 32'(req_valid), 32'd0);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    timeout_clr = 1'b1;
    tick;
    timeout_clr = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 32'd0);
    // ram_valid on the exact timeout cycle wins.
    req_read = 4'b0010;
    wait_read;
    repeat (255) tick;
    ram_valid = 1'b1;
    ram_word = 16'h5A5A;
    tick;
    ram_valid = 1'b0;
    chk("race_valid", 32'(req_valid), 32'h2);
    chk("race_word", 32'(req_word), 32'h5A5A);
    chk("race_no_err", 32'(timeout_err), 32'd0);
    req_read = 4'b0000;
    tick;
    // Asynchronous reset in BUSY, then requester 0 has priority again.
    req_read = 4'b0101;
    wait_read;
    chk("pre_rst_grant", 32'(grant), 32'h4);
    #2 rst_L = 1'b0;
    #1;
    chk("arst_read", 32'(ram_read), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_valid", 32'(req_valid), 32'd0);
    chk("arst_addr", ram_dma_addr, 32'd0);
    tick;
    rst_L = 1'b1;
    tick;
    chk("post_rst_grant", 32'(grant), 32'h1);
    chk("post_rst_read", 32'(ram_read), 32'd1);
    ram_valid = 1'b1;
    ram_word = 16'h7777;
    tick;
    ram_valid = 1'b0;
    chk("post_rst_valid", 32'(req_valid), 32'h1);
    chk("post_rst_word", 32'(req_word), 32'h7777);
    req_read = 4'b0000;
    tick;
    tick;
    chk("end_idle_grant", 32'(grant), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
